// File: rtl/add_sub_pipe_if.sv
// Producer/consumer bundle for add_sub_pipe: packed per-lane operand vectors in,
// per-lane results, flags and the accepted-result counter out.
interface add_sub_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [LANES*WIDTH-1:0] d;
  logic                   sat;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] c;
  logic [LANES*WIDTH-1:0] f;
  logic [LANES-1:0]       ovf;
  logic [LANES-1:0]       unf;
  logic [CNT_W-1:0]       out_count;

  // The pipeline block itself.
  modport slave (
    input  in_valid, a, b, d, sat, out_ready,
    output in_ready, out_valid, c, f, ovf, unf, out_count
  );

  // The surrounding producer/consumer.
  modport master (
    output in_valid, a, b, d, sat, out_ready,
    input  in_ready, out_valid, c, f, ovf, unf, out_count
  );
endinterface

// File: rtl/add_sub_pipe.sv
// Two-stage per-lane unsigned pipeline: S1 registers c = a + b (wrap/saturate),
// S2 registers f = c - d (wrap/saturate); valid/ready flow control on both ends.
module add_sub_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  add_sub_pipe_if.slave bus
);

  localparam int VW = LANES * WIDTH;

  // Handshake: a beat moves on any rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready is combinational from
  // out_ready and stage occupancy so a full pipe can accept and emit on one edge.

  logic             r_v1;
  logic [VW-1:0]    r_c1;
  logic [VW-1:0]    r_d1;
  logic             r_sat1;
  logic [LANES-1:0] r_ovf1;

  logic             r_v2;
  logic [VW-1:0]    r_c2;
  logic [VW-1:0]    r_f2;
  logic [LANES-1:0] r_ovf2;
  logic [LANES-1:0] r_unf2;

  logic [CNT_W-1:0] r_count;

  logic             w_s2_en;
  logic             w_s1_en;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [VW-1:0]    w_c1_next;
  logic [LANES-1:0] w_ovf1_next;
  logic [VW-1:0]    w_f2_next;
  logic [LANES-1:0] w_unf2_next;

  assign w_s2_en    = !r_v2 || bus.out_ready;
  assign w_s1_en    = !r_v1 || w_s2_en;
  assign w_in_xfer  = bus.in_valid && w_s1_en;
  assign w_out_xfer = r_v2 && bus.out_ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    assign w_sum = {1'b0, bus.a[gi*WIDTH +: WIDTH]} + {1'b0, bus.b[gi*WIDTH +: WIDTH]};
    assign w_ovf1_next[gi] = w_sum[WIDTH];
    assign w_c1_next[gi*WIDTH +: WIDTH] =
      (bus.sat && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    // Stage 2 works on the already wrapped/saturated c held in S1.
    assign w_borrow = r_c1[gi*WIDTH +: WIDTH] < r_d1[gi*WIDTH +: WIDTH];
    assign w_diff   = r_c1[gi*WIDTH +: WIDTH] - r_d1[gi*WIDTH +: WIDTH];
    assign w_unf2_next[gi] = w_borrow;
    assign w_f2_next[gi*WIDTH +: WIDTH] =
      (r_sat1 && w_borrow) ? {WIDTH{1'b0}} : w_diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_c1   <= '0;
      r_d1   <= '0;
      r_sat1 <= 1'b0;
      r_ovf1 <= '0;
    end else begin
      if (w_s1_en) begin
        r_v1 <= w_in_xfer;
      end
      if (w_in_xfer) begin
        r_c1   <= w_c1_next;
        r_d1   <= bus.d;
        r_sat1 <= bus.sat;
        r_ovf1 <= w_ovf1_next;
      end
    end
  end

  // S2 data only reloads from a valid S1 so idle outputs keep their last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_c2   <= '0;
      r_f2   <= '0;
      r_ovf2 <= '0;
      r_unf2 <= '0;
    end else if (w_s2_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_c2   <= r_c1;
        r_f2   <= w_f2_next;
        r_ovf2 <= r_ovf1;
        r_unf2 <= w_unf2_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_out_xfer) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_s1_en;
  assign bus.out_valid = r_v2;
  assign bus.c         = r_c2;
  assign bus.f         = r_f2;
  assign bus.ovf       = r_ovf2;
  assign bus.unf       = r_unf2;
  assign bus.out_count = r_count;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe with two 8-bit lanes and a 4-bit result counter.
module tb_add_sub_pipe;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam int VW    = WIDTH * LANES;
  localparam int EW    = 2 * VW + 2 * LANES;

  typedef struct {
    logic [VW-1:0]    a;
    logic [VW-1:0]    b;
    logic [VW-1:0]    d;
    logic             sat;
    logic [VW-1:0]    c;
    logic [VW-1:0]    f;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] unf;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_sub_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  add_sub_pipe #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_count = '0;
  vec_t             tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned per-lane sums/differences in integer form.
  function automatic logic [EW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                          input logic [VW-1:0] d, input logic sat);
    logic [VW-1:0]    c;
    logic [VW-1:0]    f;
    logic [LANES-1:0] o;
    logic [LANES-1:0] u;
    for (int i = 0; i < LANES; i++) begin
      int unsigned s;
      int unsigned ci;
      int unsigned di;
      s  = int'(a[i*WIDTH +: WIDTH]) + int'(b[i*WIDTH +: WIDTH]);
      o[i] = (s > 255);
      ci = (sat && o[i]) ? 255 : (s % 256);
      di = int'(d[i*WIDTH +: WIDTH]);
      u[i] = (ci < di);
      c[i*WIDTH +: WIDTH] = 8'(ci);
      f[i*WIDTH +: WIDTH] = (sat && u[i]) ? 8'd0 : 8'((ci + 256 - di) % 256);
    end
    return {c, f, o, u};
  endfunction

  function automatic vec_t mk(input int a1, input int a0, input int b1, input int b0,
                              input int d1, input int d0, input logic s,
                              input int c1, input int c0, input int f1, input int f0,
                              input logic [1:0] o, input logic [1:0] u);
    vec_t v;
    v.a = {8'(a1), 8'(a0)};
    v.b = {8'(b1), 8'(b0)};
    v.d = {8'(d1), 8'(d0)};
    v.sat = s;
    v.c = {8'(c1), 8'(c0)};
    v.f = {8'(f1), 8'(f0)};
    v.ovf = o;
    v.unf = u;
    return v;
  endfunction

  // scoreboard: compare every output transfer against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got c=0x%0h f=0x%0h, expected no output", bus.c, bus.f);
      end else begin
        check("result", 64'({bus.c, bus.f, bus.ovf, bus.unf}), 64'(exp_q.pop_front()));
      end
      exp_count = exp_count + CNT_W'(1);
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] d,
                      input logic sat, input logic [EW-1:0] e);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.d = d;
    bus.sat = sat;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      cycle();
      @(negedge clk);
      k++;
    end
    if (bus.in_ready) exp_q.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", k);
    end
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [VW-1:0] ra, rb, rd;
    logic rs;
    ra = VW'($urandom_range(0, 65535));
    rb = VW'($urandom_range(0, 65535));
    rd = VW'($urandom_range(0, 65535));
    rs = 1'($urandom_range(0, 1));
    send(ra, rb, rd, rs, model(ra, rb, rd, rs));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      cycle();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    end
    cycle();
  endtask

  // Reset with an input offered and the consumer ready: neither may take effect.
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_count = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
    check({tag, "_out_count"}, 64'(bus.out_count), 64'(0));
    check({tag, "_c_f"},       64'({bus.c, bus.f}), 64'(0));
    check({tag, "_flags"},     64'({bus.ovf, bus.unf}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] ra, rb, rd;
    logic rs;
    int sent;

    //                a1   a0   b1   b0   d1   d0  sat  c1   c0   f1   f0   ovf    unf
    tbl[0] = mk(  3,  15,   4,  10,  10,   5, 0,   7,  25, 253,  20, 2'b00, 2'b10);
    tbl[1] = mk(255,  20,   1,  30,   0,   8, 0,   0,  50,   0,  42, 2'b10, 2'b00);
    tbl[2] = mk(  0,   5,   0,   2,   0,   1, 0,   0,   7,   0,   6, 2'b00, 2'b00);
    tbl[3] = mk(  1, 100,   1,  50,   1,  20, 0,   2, 150,   1, 130, 2'b00, 2'b00);
    tbl[4] = mk(255, 200,   1, 100,   0,  50, 0,   0,  44,   0, 250, 2'b11, 2'b01);
    tbl[5] = mk(255, 200,   1, 100,   0,  50, 1, 255, 255, 255, 205, 2'b11, 2'b00);
    tbl[6] = mk(  3, 200,   4, 100,  10,  50, 1,   7, 255,   0, 205, 2'b01, 2'b10);
    tbl[7] = mk(  0,   0,   0,   0,   1,   0, 0,   0,   0, 255,   0, 2'b00, 2'b10);
    tbl[8] = mk(128, 255, 127, 255, 255, 255, 0, 255, 254,   0, 255, 2'b01, 2'b01);
    tbl[9] = mk(128, 255, 127, 255, 255, 255, 1, 255, 255,   0,   0, 2'b01, 2'b00);

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.d = '0;
    bus.sat = 1'b0;
    cycle();
    do_reset();
    check_reset("rst0");

    // latency: accepted at edge N, visible after edge N+1
    send(tbl[0].a, tbl[0].b, tbl[0].d, tbl[0].sat, {tbl[0].c, tbl[0].f, tbl[0].ovf, tbl[0].unf});
    check("lat_edge_n", 64'(bus.out_valid), 64'(0));
    cycle();
    check("lat_edge_n1", 64'(bus.out_valid), 64'(1));
    drain();

    // table vectors back-to-back, alternating sat on the same operands
    for (int i = 0; i < 10; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].sat, {tbl[i].c, tbl[i].f, tbl[i].ovf, tbl[i].unf});
    drain();
    check("count_table", 64'(bus.out_count), 64'(11));

    // bubble collapse, then full-pipe stall
    bus.out_ready = 1'b0;
    send_rand();
    check("collapse_in_ready", 64'(bus.in_ready), 64'(1));
    cycle();
    check("collapse_out_valid", 64'(bus.out_valid), 64'(1));
    send_rand();
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) cycle();
    check("stall_hold", 64'({bus.out_valid, bus.in_ready}), 64'(2'b10));
    bus.out_ready = 1'b1;
    drain();

    // backpressure: 6 transactions, consumer stalled for cycles 2-4
    sent = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      bus.in_valid = (sent < 6);
      ra = VW'($urandom_range(0, 65535));
      rb = VW'($urandom_range(0, 65535));
      rd = VW'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      bus.a = ra;
      bus.b = rb;
      bus.d = rd;
      bus.sat = rs;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(ra, rb, rd, rs));
        sent++;
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("bp_sent", 64'(sent), 64'(6));
    check("bp_count", 64'(bus.out_count), 64'((11 + 2 + 6) % 16));

    // random valid/ready traffic
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      ra = VW'($urandom_range(0, 65535));
      rb = VW'($urandom_range(0, 65535));
      rd = VW'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      bus.a = ra;
      bus.b = rb;
      bus.d = rd;
      bus.sat = rs;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(ra, rb, rd, rs));
        sent++;
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("rand_count", 64'(bus.out_count), 64'(exp_count));

    // reset with a full pipe, then a fresh transaction with latency 2
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    check("pre_rst_full", 64'(bus.in_ready), 64'(0));
    do_reset();
    check_reset("rst_mid");
    cycle();
    check("rst_mid_no_accept", 64'(bus.out_valid), 64'(0));
    send_rand();
    check("rst_lat_n", 64'(bus.out_valid), 64'(0));
    cycle();
    check("rst_lat_n1", 64'(bus.out_valid), 64'(1));
    drain();

    // counter wrap at 4 bits: 17 results -> 1
    do_reset();
    for (int i = 0; i < 17; i++) send_rand();
    drain();
    check("count_wrap", 64'(bus.out_count), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
